// File: rtl/pwm_pkg.sv
// Shared constants and helpers for the multi-channel PWM generator.
// Period length, counter width, percent-to-ticks conversion and duty clamping.
package pwm_pkg;

  function automatic int calc_cnt_max(input int clk_mhz, input int freq_khz);
    return (1000 * clk_mhz) / freq_khz;
  endfunction

  function automatic int calc_cnt_width(input int cnt_max);
    return (cnt_max < 1) ? 1 : $clog2(cnt_max + 1);
  endfunction

  function automatic int pct_to_ticks(input int pct, input int cnt_max);
    return (pct * cnt_max) / 100;
  endfunction

  // A duty above the period length would just mean "always high", so saturate it.
  function automatic int clamp_duty(input int duty, input int cnt_max);
    return (duty > cnt_max) ? cnt_max : duty;
  endfunction

endpackage

// File: rtl/pwm_chan.sv
// One PWM channel: phase derivation, shadow/active duty, boundary commit, output register.
// With PWM_PHASE_EN defined the channel adds a fixed phase offset to the shared counter.
module pwm_chan
  import pwm_pkg::*;
#(
  parameter int cnt_max   = 125,
  parameter int cnt_width = 7,
`ifdef PWM_PHASE_EN
  parameter int off       = 0,
`endif
  parameter int duty_rst  = 50
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [cnt_width-1:0] cnt,
  input  logic                 wr,
  input  logic [cnt_width-1:0] wr_duty,
  output logic                 out,
  output logic                 pend
);

  localparam logic [cnt_width-1:0] last_ph = cnt_width'(cnt_max - 1);
  localparam logic [cnt_width-1:0] rst_val = cnt_width'(duty_rst);

  logic [cnt_width-1:0] ph;
  logic [cnt_width-1:0] shadow;
  logic [cnt_width-1:0] active;
  logic                 boundary;

`ifdef PWM_PHASE_EN
  localparam int                 cnt_max_i = cnt_max;
  localparam int                 off_i     = off;
  localparam logic [cnt_width:0] cm_v      = cnt_max_i[cnt_width:0];
  localparam logic [cnt_width:0] off_v     = off_i[cnt_width:0];

  logic [cnt_width:0] ph_sum;
  logic [cnt_width:0] ph_wrap;

  // cnt and off are both below cnt_max, so one conditional subtract is enough.
  assign ph_sum  = {1'b0, cnt} + off_v;
  assign ph_wrap = ph_sum - cm_v;
  assign ph      = (ph_sum >= cm_v) ? ph_wrap[cnt_width-1:0] : ph_sum[cnt_width-1:0];
`else
  assign ph = cnt;
`endif

  assign boundary = (ph == last_ph);

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow <= rst_val;
      active <= rst_val;
      out    <= 1'b0;
      pend   <= 1'b0;
    end else begin
      if (wr) begin
        shadow <= wr_duty;
      end
      // A write landing on the commit edge bypasses the shadow so it is not lost.
      if (boundary) begin
        active <= wr ? wr_duty : shadow;
        pend   <= 1'b0;
      end else if (wr) begin
        pend   <= 1'b1;
      end
      out <= (ph < active);
    end
  end

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM top: shared period counter, period sync pulse and duty write decode.
// Optional PWM_PHASE_EN staggers channel phases by i*cnt_max/ch.
module pwm_multi
  import pwm_pkg::*;
#(
  parameter int  clk_mhz   = 50,
  parameter int  freq_khz  = 400,
  parameter int  ch        = 4,
  parameter int  init_duty = 40,
  localparam int cnt_max   = calc_cnt_max(clk_mhz, freq_khz),
  localparam int cnt_width = calc_cnt_width(cnt_max),
  localparam int ch_w      = (ch > 1) ? $clog2(ch) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [ch_w-1:0]      wr_ch,
  input  logic [cnt_width-1:0] wr_duty,
  output logic [ch-1:0]        out,
  output logic                 sync,
  output logic [ch-1:0]        pend
);

  localparam int                   duty_rst = pct_to_ticks(init_duty, cnt_max);
  localparam int                   ch_i     = ch;
  localparam logic [ch_w:0]        ch_lim   = ch_i[ch_w:0];
  localparam logic [cnt_width-1:0] cnt_last = cnt_width'(cnt_max - 1);

  logic [cnt_width-1:0] cnt;
  logic                 wr_ok;
  logic [cnt_width-1:0] wr_clamp;

  // Channel numbers past the last instance are dropped without side effects.
  assign wr_ok    = wr_en && ({1'b0, wr_ch} < ch_lim);
  assign wr_clamp = cnt_width'(clamp_duty(int'(wr_duty), cnt_max));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      sync <= 1'b0;
    end else begin
      cnt  <= (cnt == cnt_last) ? '0 : cnt + 1'b1;
      sync <= (cnt == '0);
    end
  end

  for (genvar i = 0; i < ch; i++) begin : g_ch
    logic wr_sel;
    assign wr_sel = wr_ok && (wr_ch == ch_w'(i));

`ifdef PWM_PHASE_EN
    localparam int off = (i * cnt_max) / ch;
    pwm_chan #(
      .cnt_max  (cnt_max),
      .cnt_width(cnt_width),
      .off      (off),
      .duty_rst (duty_rst)
    ) u_chan (
      .clk    (clk),
      .rst    (rst),
      .cnt    (cnt),
      .wr     (wr_sel),
      .wr_duty(wr_clamp),
      .out    (out[i]),
      .pend   (pend[i])
    );
`else
    pwm_chan #(
      .cnt_max  (cnt_max),
      .cnt_width(cnt_width),
      .duty_rst (duty_rst)
    ) u_chan (
      .clk    (clk),
      .rst    (rst),
      .cnt    (cnt),
      .wr     (wr_sel),
      .wr_duty(wr_clamp),
      .out    (out[i]),
      .pend   (pend[i])
    );
`endif
  end

endmodule

// File: tb/tb_pwm_multi.sv
// Scoreboard bench for pwm_multi (6 channels so out-of-range channel numbers exist).
// A period-level reference model pushes the expected outputs; a negedge monitor checks them.
module tb_pwm_multi;

  localparam int CH  = 6;
  localparam int CM  = (1000 * 50) / 400;
  localparam int CW  = $clog2(CM + 1);
  localparam int CHW = $clog2(CH);
  localparam int DR  = (40 * CM) / 100;

  typedef struct packed {
    logic [CH-1:0] o;
    logic          s;
    logic [CH-1:0] p;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           wr_en = 1'b0;
  logic [CHW-1:0] wr_ch = '0;
  logic [CW-1:0]  wr_duty = '0;
  logic [CH-1:0]  out;
  logic           sync;
  logic [CH-1:0]  pend;

  int n_checks = 0;
  int n_err = 0;

  pwm_multi #(
    .clk_mhz  (50),
    .freq_khz (400),
    .ch       (CH),
    .init_duty(40)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (wr_en),
    .wr_ch  (wr_ch),
    .wr_duty(wr_duty),
    .out    (out),
    .sync   (sync),
    .pend   (pend)
  );

  always #5 clk = ~clk;

  function automatic int offset(input int i);
`ifdef PWM_PHASE_EN
    return (i * CM) / CH;
`else
    return 0 * i;
`endif
  endfunction

  // Reference: period position, duty in use, and at most one waiting duty per channel (-1 = none).
  int   m_cnt = 0;
  int   act[CH];
  int   pnd[CH];
  exp_t q[$];

  always @(posedge clk) begin
    exp_t e;
    e = '0;
    if (rst) begin
      m_cnt = 0;
      for (int i = 0; i < CH; i++) begin
        act[i] = DR;
        pnd[i] = -1;
      end
    end else begin
      e.s = (m_cnt == 0);
      for (int i = 0; i < CH; i++) begin
        e.o[i] = (((m_cnt + offset(i)) % CM) < act[i]);
      end
      if (wr_en && int'(wr_ch) < CH) begin
        pnd[int'(wr_ch)] = (int'(wr_duty) > CM) ? CM : int'(wr_duty);
      end
      for (int i = 0; i < CH; i++) begin
        if (((m_cnt + offset(i)) % CM) == CM - 1 && pnd[i] >= 0) begin
          act[i] = pnd[i];
          pnd[i] = -1;
        end
        e.p[i] = (pnd[i] >= 0);
      end
      m_cnt = (m_cnt + 1) % CM;
    end
    q.push_back(e);
  end

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      n_checks += 3;
      if (out !== e.o) begin
        n_err++;
        $display("FAIL out t=%0t got %b expected %b", $time, out, e.o);
      end
      if (sync !== e.s) begin
        n_err++;
        $display("FAIL sync t=%0t got %b expected %b", $time, sync, e.s);
      end
      if (pend !== e.p) begin
        n_err++;
        $display("FAIL pend t=%0t got %b expected %b", $time, pend, e.p);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cnt(input int k);
    int n;
    n = 0;
    while (m_cnt != k && n < 300) begin
      tick();
      n++;
    end
    if (m_cnt != k) begin
      n_checks++;
      n_err++;
      $display("FAIL wait_cnt got %0d expected %0d", m_cnt, k);
    end
  endtask

  task automatic write(input int c, input int d);
    wr_en   = 1'b1;
    wr_ch   = CHW'(c);
    wr_duty = CW'(d);
    tick();
    wr_en   = 1'b0;
  endtask

  initial begin
    int hi;
    int sy;
    repeat (3) tick();
    rst = 1'b0;

    // Default duty: 50 high of 125, one sync per period.
    tick();
    hi = 0;
    sy = 0;
    for (int k = 0; k < CM; k++) begin
      tick();
      hi += int'(out[0]);
      sy += int'(sync);
    end
    n_checks += 2;
    if (hi != DR) begin
      n_err++;
      $display("FAIL high_count got %0d expected %0d", hi, DR);
    end
    if (sy != 1) begin
      n_err++;
      $display("FAIL sync_count got %0d expected 1", sy);
    end

    wait_cnt(30);
    write(1, 0);
    repeat (130) tick();

    write(2, 125);
    write(3, 200);
    write(6, 7);
    write(7, 3);
    repeat (130) tick();

    wait_cnt(124);
    write(0, 10);
    repeat (130) tick();

    wait_cnt(10);
    write(0, 90);
    wait_cnt(60);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (260) tick();

    for (int k = 0; k < 1500; k++) begin
      wr_en   = ($urandom_range(0, 9) < 3);
      wr_ch   = CHW'($urandom_range(0, (1 << CHW) - 1));
      wr_duty = CW'($urandom_range(0, (1 << CW) - 1));
      rst     = ($urandom_range(0, 299) == 0);
      tick();
    end
    wr_en = 1'b0;
    rst   = 1'b0;
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
